// File: rtl/e_encoder16to4_seq.sv
// Sequential mask-to-index encoder: accepts a one-hot-or-more mask and streams the
// index of every set bit, lowest first, one per output handshake.
module e_encoder16to4_seq #(
    parameter int N_IN   = 16,
    parameter int CODE_W = 4     // must equal log2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out,
    output logic              out_last,
    output logic [CODE_W:0]   count,
    output logic              none
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [N_IN-1:0]   pending_reg, pending_next;
    logic [CODE_W:0]   count_reg, count_next;
    logic              none_reg, none_next;

    logic [N_IN-1:0]   low_bit;
    logic [CODE_W-1:0] low_index;
    logic              single_bit;
    logic [CODE_W:0]   in_popcount;
    logic              busy;

    // Two's-complement trick isolates the lowest set bit of the pending mask.
    assign low_bit    = pending_reg & (~pending_reg + ONE);
    assign single_bit = (pending_reg != '0) && ((pending_reg & (pending_reg - ONE)) == '0);

    // One-hot to binary: index bit gi is the OR of every one-hot position whose
    // binary number has bit gi set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < CODE_W; gi++) begin : g_code_bit
            logic [N_IN-1:0] sel;
            for (gj = 0; gj < N_IN; gj++) begin : g_pos
                if (((gj >> gi) & 1) != 0) begin : g_on
                    assign sel[gj] = low_bit[gj];
                end else begin : g_off
                    assign sel[gj] = 1'b0;
                end
            end
            assign low_index[gi] = |sel;
        end
    endgenerate

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_popcount = in_popcount + (CODE_W+1)'(in[i]);
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        count_next   = count_reg;
        none_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (in != '0) begin
                        pending_next = in;
                        count_next   = in_popcount;
                        state_next   = BUSY;
                    end else begin
                        count_next = '0;
                        none_next  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pending_next = pending_reg & ~low_bit;
                    if (single_bit) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            count_reg   <= '0;
            none_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            count_reg   <= count_next;
            none_reg    <= none_next;
        end
    end

    // Outputs come only from registers; index outputs are forced to 0 when idle.
    assign busy      = (state_reg == BUSY);
    assign in_ready  = !busy;
    assign out_valid = busy;
    assign out       = busy ? low_index : '0;
    assign out_last  = busy && single_bit;
    assign count     = count_reg;
    assign none      = none_reg;

endmodule

// File: tb/tb_e_encoder16to4_seq.sv
// Bench for e_encoder16to4_seq: directed scenarios plus random masks, checked
// against an index list derived directly from each mask.
module tb_e_encoder16to4_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out;
    logic        out_last;
    logic [4:0]  count;
    logic        none;

    int checks = 0;
    int errors = 0;

    e_encoder16to4_seq #(.N_IN(16), .CODE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last),
        .count     (count),
        .none      (none)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer one mask, then drain every beat. mode 0: always ready,
    // 1: ready toggles 1/0 each cycle, 2: random ready with bounded stalls.
    task automatic send(input logic [15:0] mask, input int mode);
        int  q[$];
        int  k;
        int  stalls;
        bit  toggle;
        bit  rdy;
        q = {};
        for (int i = 0; i < 16; i++) if (mask[i]) q.push_back(i);
        @(negedge clk);
        chk("in_ready_before", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = mask;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        $display("mask=%04h beats=%0d mode=%0d", mask, q.size(), mode);
        if (q.size() == 0) begin
            chk("none_pulse", 32'(none), 32'd1);
            chk("none_no_valid", 32'(out_valid), 32'd0);
            chk("none_count", 32'(count), 32'd0);
            chk("none_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            chk("none_clear", 32'(none), 32'd0);
            chk("none_no_valid2", 32'(out_valid), 32'd0);
            return;
        end
        chk("count", 32'(count), 32'(q.size()));
        k = 0;
        stalls = 0;
        toggle = 1'b1;
        while (k < q.size()) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("out_index", 32'(out), 32'(q[k]));
            chk("out_last", 32'(out_last), 32'(k == q.size() - 1));
            chk("count_hold", 32'(count), 32'(q.size()));
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = toggle; toggle = ~toggle; end
                default: rdy = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            stalls    = rdy ? 0 : stalls + 1;
            in_valid  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = 16'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            if (rdy) begin
                $display("  beat index=%0d last=%0d", q[k], k == q.size() - 1);
                k++;
            end
        end
        out_ready = 1'b0;
        chk("done_no_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_out_zero", 32'(out), 32'd0);
        chk("done_last_zero", 32'(out_last), 32'd0);
        chk("done_count", 32'(count), 32'(q.size()));
    endtask

    initial begin
        logic [15:0] m;
        // 1. reset while a mask is offered
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00F0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_none", 32'(none), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        $display("reset sequence done");

        // 2-5. directed masks
        send(16'h8001, 0);
        send(16'hA5A5, 1);
        send(16'h0000, 0);
        send(16'hFFFF, 0);

        // 6. reset in the middle of a burst
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0F00;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("mid_b0", 32'(out), 32'd8);
        @(negedge clk);
        chk("mid_b1", 32'(out), 32'd9);
        @(negedge clk);
        chk("mid_b2", 32'(out), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        $display("mid-burst reset applied");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);
        send(16'h0002, 0);

        // random masks, random back-pressure, random in_valid noise while busy
        for (int t = 0; t < 24; t++) begin
            case (t % 4)
                0:       m = 16'($urandom);
                1:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2:       m = (t % 8 == 2) ? 16'h0000 : 16'(1 << $urandom_range(0, 15));
                default: m = ~(16'(1 << $urandom_range(0, 15)));
            endcase
            send(m, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
